// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared types and format helpers for the fp_mul_pipe multiplier.
package fp_mul_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } r_mode_e;

    typedef enum logic [2:0] {
        CL_ZERO,
        CL_NORM,
        CL_INF,
        CL_QNAN,
        CL_SNAN
    } fp_class_e;

    typedef logic [127:0] fp_bits_t;

    function automatic int bias_f(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    function automatic int emax_f(input int ew);
        return (1 << ew) - 1;
    endfunction

    function automatic fp_bits_t qnan_f(input int ew, input int fw);
        fp_bits_t ones;
        ones = (fp_bits_t'(1) << ew) - fp_bits_t'(1);
        return (ones << fw) | (fp_bits_t'(1) << (fw - 1));
    endfunction

    function automatic fp_bits_t maxfin_f(input int ew, input int fw);
        fp_bits_t e_max;
        e_max = (fp_bits_t'(1) << ew) - fp_bits_t'(2);
        return (e_max << fw) | ((fp_bits_t'(1) << fw) - fp_bits_t'(1));
    endfunction

endpackage

// File: rtl/fp_round_unit.sv
// fp_round_unit: applies the rounding mode, then saturates on overflow
// and flushes to zero on underflow.
module fp_round_unit
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic                    sign_i,
    input  logic [FRC_W-1:0]        frac_i,
    input  logic                    g_i,
    input  logic                    r_i,
    input  logic                    s_i,
    input  logic signed [EXP_W+1:0] exp_i,
    input  r_mode_e                 rm_i,
    output logic [FRC_W-1:0]        frac_o,
    output logic [EXP_W-1:0]        exp_o,
    output logic                    ovrf_o,
    output logic                    udrf_o
);
    localparam int EW2 = EXP_W + 2;
    localparam int FW1 = FRC_W + 1;
    localparam int EF  = EXP_W + FRC_W;
    localparam logic signed [EW2-1:0] EMAX_S = EW2'(emax_f(EXP_W));
    localparam logic signed [EW2-1:0] ZERO_S = '0;
    localparam logic [EF-1:0] MAXF_P = EF'(maxfin_f(EXP_W, FRC_W));
    localparam logic [EF-1:0] INF_P  = {{EXP_W{1'b1}}, {FRC_W{1'b0}}};

    logic                  any;
    logic                  inc;
    logic                  to_inf;
    logic                  carry;
    logic [FRC_W-1:0]      frac_r;
    logic signed [EW2-1:0] exp_r;

    always_comb begin
        any    = g_i | r_i | s_i;
        inc    = g_i & (r_i | s_i | frac_i[0]);
        to_inf = 1'b1;
        unique case (rm_i)
            RM_RTZ: begin inc = 1'b0;           to_inf = 1'b0;    end
            RM_RDN: begin inc = sign_i & any;   to_inf = sign_i;  end
            RM_RUP: begin inc = !sign_i & any;  to_inf = !sign_i; end
            RM_RMM: inc = g_i;
            default: ;
        endcase
        // a carry out of the fraction leaves it at zero with exponent + 1
        {carry, frac_r} = {1'b0, frac_i} + FW1'(inc);
        exp_r  = exp_i + EW2'(carry);
        udrf_o = exp_i <= ZERO_S;
        ovrf_o = !udrf_o && (exp_r >= EMAX_S);
        {exp_o, frac_o} = {exp_r[EXP_W-1:0], frac_r};
        if (udrf_o) begin
            {exp_o, frac_o} = '0;
        end else if (ovrf_o) begin
            {exp_o, frac_o} = to_inf ? INF_P : MAXF_P;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined floating-point multiplier, valid/ready both sides.
// Defining FP_MUL_INEXACT_EN adds the inexact output nx.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int FRC_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+FRC_W:0] fp_X,
    input  logic [EXP_W+FRC_W:0] fp_Y,
    input  logic [2:0]           r_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+FRC_W:0] fp_Z,
    output logic                 ovrf,
    output logic                 udrf,
    output logic                 nv
`ifdef FP_MUL_INEXACT_EN
    ,
    output logic                 nx
`endif
);
    localparam int W   = 1 + EXP_W + FRC_W;
    localparam int MW  = FRC_W + 1;
    localparam int PW  = 2 * MW;
    localparam int EW2 = EXP_W + 2;
    localparam logic [W-1:0] QNAN_P = W'(qnan_f(EXP_W, FRC_W));
    localparam logic signed [EW2-1:0] BIAS_S = EW2'(bias_f(EXP_W));

    function automatic fp_class_e cls_f(
        input logic [EXP_W-1:0] e,
        input logic [FRC_W-1:0] f
    );
        fp_class_e c;
        unique case (1'b1)
            (e == '0):                       c = CL_ZERO;
            (&e && f == '0):                 c = CL_INF;
            (&e && f[FRC_W-1]):              c = CL_QNAN;
            (&e && f != '0 && !f[FRC_W-1]):  c = CL_SNAN;
            default:                         c = CL_NORM;
        endcase
        return c;
    endfunction

    logic en1, en2, en3;
    logic s1_v_q, s2_v_q, out_v_q;

    assign en3       = !out_v_q || out_ready;
    assign en2       = !s2_v_q || en3;
    assign en1       = !s1_v_q || en2;
    assign in_ready  = en1;
    assign out_valid = out_v_q;

    logic             sx, sy;
    logic [EXP_W-1:0] ex, ey;
    logic [FRC_W-1:0] fx, fy;
    fp_class_e        cx, cy;
    logic             nan_any, snan_any, inf_any, zero_any, inf_zero;
    logic             s1_spec_d, s1_nv_d;
    logic [W-1:0]     s1_spz_d;

    assign {sx, ex, fx} = fp_X;
    assign {sy, ey, fy} = fp_Y;
    assign cx = cls_f(ex, fx);
    assign cy = cls_f(ey, fy);

    always_comb begin
        snan_any = (cx == CL_SNAN) || (cy == CL_SNAN);
        nan_any  = snan_any || (cx == CL_QNAN) || (cy == CL_QNAN);
        inf_any  = (cx == CL_INF) || (cy == CL_INF);
        zero_any = (cx == CL_ZERO) || (cy == CL_ZERO);
        inf_zero = inf_any && zero_any;
        s1_spec_d = 1'b1;
        s1_nv_d   = 1'b0;
        s1_spz_d  = '0;
        if (nan_any || inf_zero) begin
            s1_spz_d = QNAN_P;
            s1_nv_d  = snan_any || inf_zero;
        end else if (inf_any) begin
            s1_spz_d = {sx ^ sy, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
        end else if (zero_any) begin
            s1_spz_d = {sx ^ sy, {(W-1){1'b0}}};
        end else begin
            s1_spec_d = 1'b0;
        end
    end

    logic                  s1_sg_q, s1_spec_q, s1_nv_q;
    logic [W-1:0]          s1_spz_q;
    logic [PW-1:0]         s1_prod_q;
    logic signed [EW2-1:0] s1_e_q;
    r_mode_e               s1_rm_q;

    logic                  msb;
    logic [FRC_W-1:0]      s2_frc_d;
    logic                  s2_g_d, s2_r_d, s2_st_d;
    logic signed [EW2-1:0] s2_e_d;

    // product is in [1,4); a set MSB means one extra integer bit to drop
    always_comb begin
        msb = s1_prod_q[PW-1];
        if (msb) begin
            s2_frc_d = s1_prod_q[PW-2 -: FRC_W];
            s2_g_d   = s1_prod_q[MW-1];
            s2_r_d   = s1_prod_q[MW-2];
            s2_st_d  = |s1_prod_q[MW-3:0];
        end else begin
            s2_frc_d = s1_prod_q[PW-3 -: FRC_W];
            s2_g_d   = s1_prod_q[MW-2];
            s2_r_d   = s1_prod_q[MW-3];
            s2_st_d  = |s1_prod_q[MW-4:0];
        end
        s2_e_d = s1_e_q + EW2'(msb);
    end

    logic                  s2_sg_q, s2_spec_q, s2_nv_q;
    logic [W-1:0]          s2_spz_q;
    logic [FRC_W-1:0]      s2_frc_q;
    logic                  s2_g_q, s2_r_q, s2_st_q;
    logic signed [EW2-1:0] s2_e_q;
    r_mode_e               s2_rm_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
        end else begin
            if (en1) s1_v_q <= in_valid;
            if (en2) s2_v_q <= s1_v_q;
        end
    end

    always_ff @(posedge clk) begin
        if (en1) begin
            s1_sg_q   <= sx ^ sy;
            s1_spec_q <= s1_spec_d;
            s1_nv_q   <= s1_nv_d;
            s1_spz_q  <= s1_spz_d;
            s1_prod_q <= PW'({1'b1, fx}) * PW'({1'b1, fy});
            s1_e_q    <= $signed({2'b00, ex}) + $signed({2'b00, ey}) - BIAS_S;
            s1_rm_q   <= r_mode_e'(r_mode);
        end
        if (en2) begin
            s2_sg_q   <= s1_sg_q;
            s2_spec_q <= s1_spec_q;
            s2_nv_q   <= s1_nv_q;
            s2_spz_q  <= s1_spz_q;
            s2_frc_q  <= s2_frc_d;
            s2_g_q    <= s2_g_d;
            s2_r_q    <= s2_r_d;
            s2_st_q   <= s2_st_d;
            s2_e_q    <= s2_e_d;
            s2_rm_q   <= s1_rm_q;
        end
    end

    logic [FRC_W-1:0] ru_frac;
    logic [EXP_W-1:0] ru_exp;
    logic             ru_ovf, ru_udf;
    logic             fin_v;

    fp_round_unit #(
        .EXP_W (EXP_W),
        .FRC_W (FRC_W)
    ) u_round (
        .sign_i (s2_sg_q),
        .frac_i (s2_frc_q),
        .g_i    (s2_g_q),
        .r_i    (s2_r_q),
        .s_i    (s2_st_q),
        .exp_i  (s2_e_q),
        .rm_i   (s2_rm_q),
        .frac_o (ru_frac),
        .exp_o  (ru_exp),
        .ovrf_o (ru_ovf),
        .udrf_o (ru_udf)
    );

    assign fin_v = s2_v_q && !s2_spec_q;

    logic [W-1:0] z_q;
    logic         ovf_q, udf_q, nv_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_v_q <= 1'b0;
            z_q     <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            nv_q    <= 1'b0;
        end else if (en3) begin
            out_v_q <= s2_v_q;
            z_q     <= s2_spec_q ? s2_spz_q : {s2_sg_q, ru_exp, ru_frac};
            ovf_q   <= fin_v && ru_ovf;
            udf_q   <= fin_v && ru_udf;
            nv_q    <= s2_v_q && s2_spec_q && s2_nv_q;
        end
    end

    assign fp_Z = z_q;
    assign ovrf = ovf_q;
    assign udrf = udf_q;
    assign nv   = nv_q;

`ifdef FP_MUL_INEXACT_EN
    logic nx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nx_q <= 1'b0;
        end else if (en3) begin
            nx_q <= fin_v && (ru_ovf | ru_udf | s2_g_q | s2_r_q | s2_st_q);
        end
    end

    assign nx = nx_q;
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed and randomized checks of fp_mul_pipe (binary32)
// against an exact-integer reference model kept in the bench.
module tb_fp_mul_pipe;

    typedef struct {
        logic [31:0] z;
        logic        o;
        logic        u;
        logic        v;
        logic        x;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fp_X;
    logic [31:0] fp_Y;
    logic [2:0]  r_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fp_Z;
    logic        ovrf;
    logic        udrf;
    logic        nv;
`ifdef FP_MUL_INEXACT_EN
    logic        nx;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   lat_chk;
    exp_t nxt;
    exp_t exp_q[$];

    fp_mul_pipe #(
        .EXP_W (8),
        .FRC_W (23)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp_X      (fp_X),
        .fp_Y      (fp_Y),
        .r_mode    (r_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_Z      (fp_Z),
        .ovrf      (ovrf),
        .udrf      (udrf),
        .nv        (nv)
`ifdef FP_MUL_INEXACT_EN
        ,
        .nx        (nx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Exact reference: integer product, rounding decided by comparing the
    // discarded remainder with half an ulp.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic [2:0] rm);
        exp_t        r;
        bit          s, xz, yz, xi, yi, xn, yn, inc, to_inf;
        longint unsigned p, q, rem, half;
        int          sh, e;
        r.z = '0; r.o = 0; r.u = 0; r.v = 0; r.x = 0; r.acc = 0;
        s  = x[31] ^ y[31];
        xz = x[30:23] == 8'h00;
        yz = y[30:23] == 8'h00;
        xi = x[30:23] == 8'hFF && x[22:0] == 0;
        yi = y[30:23] == 8'hFF && y[22:0] == 0;
        xn = x[30:23] == 8'hFF && x[22:0] != 0;
        yn = y[30:23] == 8'hFF && y[22:0] != 0;
        if (xn || yn || (xi && yz) || (yi && xz)) begin
            r.z = 32'h7FC00000;
            r.v = (xn && !x[22]) || (yn && !y[22]) || (xi && yz) || (yi && xz);
            return r;
        end
        if (xi || yi) begin
            r.z = {s, 8'hFF, 23'h0};
            return r;
        end
        if (xz || yz) begin
            r.z = {s, 31'h0};
            return r;
        end
        p    = {40'd0, 1'b1, x[22:0]} * {40'd0, 1'b1, y[22:0]};
        sh   = p[47] ? 24 : 23;
        q    = p >> sh;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        e    = int'(x[30:23]) + int'(y[30:23]) - 127 + (sh - 23);
        if (e <= 0) begin
            r.z = {s, 31'h0}; r.u = 1; r.x = 1;
            return r;
        end
        case (rm)
            3'd1:    begin inc = 0;                 to_inf = 0;  end
            3'd2:    begin inc = s && rem != 0;     to_inf = s;  end
            3'd3:    begin inc = !s && rem != 0;    to_inf = !s; end
            3'd4:    begin inc = rem >= half;       to_inf = 1;  end
            default: begin
                inc = rem > half || (rem == half && q[0]);
                to_inf = 1;
            end
        endcase
        q = q + 64'(inc);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) begin
            r.o = 1; r.x = 1;
            r.z = to_inf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
            return r;
        end
        r.z = {s, e[7:0], q[22:0]};
        r.x = rem != 0;
        return r;
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 9))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 20));
            3:       e = 8'($urandom_range(230, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        f = 23'($urandom);
        case ($urandom_range(0, 7))
            0:       f = '0;
            1:       f = '1;
            default: ;
        endcase
        return {1'($urandom), e, f};
    endfunction

    // One clock cycle: drive at negedge, observe 1 time unit later.
    task automatic step(input logic iv, input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] rm, input logic ordy, output bit acc);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        fp_X      = x;
        fp_Y      = y;
        r_mode    = rm;
        out_ready = ordy;
        #1;
        cyc++;
        if (out_valid && out_ready) begin
            chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("fp_Z", 64'(fp_Z), 64'(e.z));
                chk("flags_ovf_udf_nv", 64'({ovrf, udrf, nv}), 64'({e.o, e.u, e.v}));
`ifdef FP_MUL_INEXACT_EN
                chk("nx", 64'(nx), 64'(e.x));
`endif
                if (lat_chk) chk("latency", 64'(cyc - e.acc), 64'd3);
            end
        end else if (!out_valid) begin
            chk("idle_flags", 64'({ovrf, udrf, nv}), 64'd0);
        end
        acc = in_valid && in_ready;
        if (acc) begin
            e     = nxt;
            e.acc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        bit acc;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++)
            step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, acc);
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic dir_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [2:0] rm, input logic [31:0] z,
                          input logic o, input logic u, input logic v,
                          input logic nxe);
        bit acc;
        nxt.z = z; nxt.o = o; nxt.u = u; nxt.v = v; nxt.x = nxe; nxt.acc = 0;
        step(1'b1, x, y, rm, 1'b1, acc);
        chk("dir_accept", 64'(acc), 64'd1);
        drain("dir_drain");
    endtask

    initial begin
        bit          acc;
        int          idx;
        logic [31:0] bx[5];
        logic [31:0] by[5];
        logic [31:0] rx, ry;
        logic [2:0]  rrm;
        logic        riv, rrdy;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        fp_X = '0; fp_Y = '0; r_mode = '0; lat_chk = 1'b1;
        nxt.z = '0; nxt.o = 0; nxt.u = 0; nxt.v = 0; nxt.x = 0; nxt.acc = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fp_Z", 64'(fp_Z), 64'd0);
        chk("rst_flags", 64'({ovrf, udrf, nv}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        dir_op(32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 0, 0, 0, 0);
        dir_op(32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 1, 0, 0, 1);
        dir_op(32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 1, 0, 0, 1);
        dir_op(32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 1, 0, 0, 1);
        dir_op(32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 1, 0, 0, 1);
        dir_op(32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 0, 1, 0, 1);
        dir_op(32'h80400000, 32'h3F800000, 3'd0, 32'h80000000, 0, 0, 0, 0);
        dir_op(32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 0, 0, 1, 0);
        dir_op(32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 0, 0, 0, 0);
        dir_op(32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 0, 0, 1, 0);
        dir_op(32'h7FC00001, 32'hFF800000, 3'd0, 32'h7FC00000, 0, 0, 0, 0);
        dir_op(32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 0, 0, 0, 1);
        dir_op(32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 0, 0, 0, 1);
        dir_op(32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 0, 0, 0, 1);
        dir_op(32'h3F800001, 32'h3F800001, 3'd4, 32'h3F800002, 0, 0, 0, 1);
        dir_op(32'h3F800001, 32'h3F800001, 3'd7, 32'h3F800002, 0, 0, 0, 1);

        // back-to-back stream at full throughput
        for (int i = 0; i < 40; i++) begin
            rx = rnd_op(); ry = rnd_op(); rrm = 3'($urandom_range(0, 7));
            nxt = model(rx, ry, rrm);
            step(1'b1, rx, ry, rrm, 1'b1, acc);
            chk("stream_accept", 64'(acc), 64'd1);
        end
        drain("stream_drain");

        // backpressure: only three operations fit while the sink stalls
        lat_chk = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bx[i] = rnd_op();
            by[i] = rnd_op();
        end
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            if (idx < 5) nxt = model(bx[idx], by[idx], 3'd0);
            step(idx < 5, bx[idx % 5], by[idx % 5], 3'd0, 1'b0, acc);
            if (acc) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'd3);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        for (int c = 0; c < 30 && (idx < 5 || exp_q.size() != 0); c++) begin
            if (idx < 5) nxt = model(bx[idx], by[idx], 3'd0);
            step(idx < 5, bx[idx % 5], by[idx % 5], 3'd0, 1'b1, acc);
            if (acc) idx++;
        end
        chk("bp_all_issued", 64'(idx), 64'd5);
        chk("bp_all_out", 64'(exp_q.size()), 64'd0);

        // random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            rx = rnd_op(); ry = rnd_op(); rrm = 3'($urandom_range(0, 7));
            riv = $urandom_range(0, 3) != 0;
            rrdy = $urandom_range(0, 3) != 0;
            nxt = model(rx, ry, rrm);
            step(riv, rx, ry, rrm, rrdy, acc);
        end
        drain("rand_drain");

        // reset in the middle of a stream drops everything in flight
        for (int i = 0; i < 4; i++) begin
            rx = rnd_op(); ry = rnd_op();
            nxt = model(rx, ry, 3'd0);
            step(1'b1, rx, ry, 3'd0, 1'b1, acc);
        end
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_flags", 64'({ovrf, udrf, nv}), 64'd0);
        exp_q.delete();
        for (int i = 0; i < 8; i++)
            step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, acc);
        lat_chk = 1'b1;
        dir_op(32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
